mmio_ram: RTL and testbench

//  Data RAM for the processor with a parametrised memory-mapped channel window. Each channel
//  is a peripheral register (motor position, chip motor, ...) driven onto a flat output bus.

---
 rtl/mmio_ram_pkg.sv | 30 +++
 rtl/mmio_channel.sv | 80 ++++++++
 rtl/mmio_ram.sv | 137 +++++++++++++
 tb/tb_mmio_ram.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_ram_pkg.sv
// mmio_ram_pkg
//   Shared definitions for the mmio_ram data RAM and its channel window:
//   - default address map (first channel address, status register address)
//   - bit offsets of the fields inside the status word
//   - address decode result type
package mmio_ram_pkg;

    localparam int unsigned DEF_CH_BASE     = 9;
    localparam int unsigned DEF_STATUS_ADDR = 14;

    // Result of decoding a CPU address. The top level resolves overlaps in the
    // order channel window, status register, RAM, unmapped.
    typedef enum logic [1:0] {
        DEC_RAM,
        DEC_CH,
        DEC_STATUS,
        DEC_NONE
    } dec_e;

    // Pending (valid) flags occupy the lowest NUM_CH bits of the status word.
    function automatic int unsigned status_valid_lsb();
        return 0;
    endfunction

    // Overrun flags sit directly above the pending flags.
    function automatic int unsigned status_ovr_lsb(input int unsigned num_ch);
        return num_ch;
    endfunction

endpackage

// File: rtl/mmio_channel.sv
// mmio_channel
//   One memory-mapped peripheral register with a valid/ready handshake toward
//   its consumer and a sticky overrun flag.
// Ports
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   wr       in   CPU write strobe for this channel
//   wdata    in   CPU write data
//   ready    in   consumer accepts the current value
//   clr_ovr  in   clear the overrun flag (status register write-1-to-clear)
//   value    out  last value written by the CPU
//   valid    out  value holds an update the consumer has not taken yet
//   overrun  out  sticky: an update was replaced before it was consumed
// Handshake: a transfer happens on every rising edge where valid and ready are
// both 1. valid never depends combinationally on ready; the consumer may raise
// ready at any time and ready without valid has no effect.
module mmio_channel #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ready,
    input  logic                  clr_ovr,
    output logic [DATA_WIDTH-1:0] value,
    output logic                  valid,
    output logic                  overrun
);

    logic [DATA_WIDTH-1:0] value_q, value_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  xfer;

    always_comb begin
        xfer = valid_q & ready;

        value_d = value_q;
        if (wr) begin
            value_d = wdata;
        end

        // A write in the same cycle as a transfer reloads valid: the old value
        // has been consumed and the new one is pending.
        valid_d = valid_q;
        if (xfer) begin
            valid_d = 1'b0;
        end
        if (wr) begin
            valid_d = 1'b1;
        end

        // Set is applied after clear so it wins if both ever coincide.
        overrun_d = overrun_q;
        if (clr_ovr) begin
            overrun_d = 1'b0;
        end
        if (wr && valid_q && !ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign value   = value_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/mmio_ram.sv
// mmio_ram
//   Processor data RAM with a window of memory-mapped channel registers and a
//   status register.
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   wEn         in   write enable
//   addr        in   word address
//   dataIn      in   write data
//   dataOut     out  registered read data, loaded on cycles with wEn=0
//   ch_value    out  flat channel bus, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ch_valid    out  per-channel pending update
//   ch_ready    in   per-channel consumer accept
//   ch_overrun  out  per-channel sticky overrun
// Status word: [NUM_CH-1:0] pending flags, [2*NUM_CH-1:NUM_CH] overrun flags,
// all other bits 0. Writing it clears overrun flags whose bit is 1.
// The RAM array has no reset; its contents come from configuration.
module mmio_ram
    import mmio_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned DEPTH         = 20,
    parameter int unsigned NUM_CH        = 5,
    parameter int unsigned CH_BASE       = DEF_CH_BASE,
    parameter int unsigned STATUS_ADDR   = DEF_STATUS_ADDR
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wEn,
    input  logic [ADDRESS_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]        dataIn,
    output logic [DATA_WIDTH-1:0]        dataOut,
    output logic [NUM_CH*DATA_WIDTH-1:0] ch_value,
    output logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH-1:0]            ch_ready,
    output logic [NUM_CH-1:0]            ch_overrun
);

    localparam int unsigned RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned VAL_LSB = status_valid_lsb();
    localparam int unsigned OVR_LSB = status_ovr_lsb(NUM_CH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    dec_e                  dec;
    logic [NUM_CH-1:0]     ch_sel;
    logic [NUM_CH-1:0]     ch_wr;
    logic [NUM_CH-1:0]     ch_clr;
    logic [RAM_AW-1:0]     ram_idx;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] status_word;
    logic [DATA_WIDTH-1:0] ch_rd;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    // Address decode. The channel window is checked first so it shadows any
    // RAM words it overlaps.
    always_comb begin
        ch_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (addr == ADDRESS_WIDTH'(CH_BASE + i));
        end

        if (|ch_sel) begin
            dec = DEC_CH;
        end else if (addr == ADDRESS_WIDTH'(STATUS_ADDR)) begin
            dec = DEC_STATUS;
        end else if (addr < ADDRESS_WIDTH'(DEPTH)) begin
            dec = DEC_RAM;
        end else begin
            dec = DEC_NONE;
        end
    end

    // Write strobes and read mux.
    always_comb begin
        ram_idx = addr[RAM_AW-1:0];
        ram_we  = wEn && (dec == DEC_RAM);
        ch_wr   = (wEn && (dec == DEC_CH)) ? ch_sel : '0;
        ch_clr  = (wEn && (dec == DEC_STATUS)) ? dataIn[OVR_LSB +: NUM_CH] : '0;

        status_word                      = '0;
        status_word[VAL_LSB +: NUM_CH]   = ch_valid;
        status_word[OVR_LSB +: NUM_CH]   = ch_overrun;

        ch_rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel[i]) begin
                ch_rd = ch_rd | ch_value[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end

        unique case (dec)
            DEC_RAM:    rd_data = mem[ram_idx];
            DEC_CH:     rd_data = ch_rd;
            DEC_STATUS: rd_data = status_word;
            default:    rd_data = '0;
        endcase

        // Read data is only captured on non-write cycles.
        data_out_d = wEn ? data_out_q : rd_data;
    end

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= dataIn;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign dataOut = data_out_q;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        mmio_channel #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr      (ch_wr[gi]),
            .wdata   (dataIn),
            .ready   (ch_ready[gi]),
            .clr_ovr (ch_clr[gi]),
            .value   (ch_value[gi*DATA_WIDTH +: DATA_WIDTH]),
            .valid   (ch_valid[gi]),
            .overrun (ch_overrun[gi])
        );
    end

endmodule

// File: tb/tb_mmio_ram.sv
// tb_mmio_ram
//   Directed bench for mmio_ram. Stimulus drives one cycle at a time on the
//   falling edge and queues the values it expects right after the following
//   rising edge; a monitor samples the DUT 1 time unit after each rising edge
//   (or after an asynchronous reset assertion) and pops those expectations.
module tb_mmio_ram;

    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int NCH = 5;

    localparam int SEL_DOUT  = 0;
    localparam int SEL_VALID = 1;
    localparam int SEL_OVR   = 2;
    localparam int SEL_VAL0  = 3;  // SEL_VAL0 + i selects channel i value

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               wEn = 1'b0;
    logic [AW-1:0]      addr = 12'd100;
    logic [DW-1:0]      dataIn = '0;
    logic [DW-1:0]      dataOut;
    logic [NCH*DW-1:0]  ch_value;
    logic [NCH-1:0]     ch_valid;
    logic [NCH-1:0]     ch_ready = '0;
    logic [NCH-1:0]     ch_overrun;

    mmio_ram #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .DEPTH         (20),
        .NUM_CH        (NCH),
        .CH_BASE       (9),
        .STATUS_ADDR   (14)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wEn        (wEn),
        .addr       (addr),
        .dataIn     (dataIn),
        .dataOut    (dataOut),
        .ch_value   (ch_value),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .ch_overrun (ch_overrun)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            sel_q[$];
    string         name_q[$];
    int            chk_req = 0;
    int            chk_cnt = 0;
    int            pass_cnt = 0;

    function automatic logic [DW-1:0] actual(input int sel);
        logic [DW-1:0] r;
        r = '0;
        if (sel == SEL_DOUT)       r = dataOut;
        else if (sel == SEL_VALID) r = DW'(ch_valid);
        else if (sel == SEL_OVR)   r = DW'(ch_overrun);
        else                       r = ch_value[(sel-SEL_VAL0)*DW +: DW];
        return r;
    endfunction

    task automatic expect_val(input int sel, input logic [DW-1:0] exp, input string name);
        exp_q.push_back(exp);
        sel_q.push_back(sel);
        name_q.push_back(name);
        chk_req = chk_req + 1;
    endtask

    // Monitor: the pending expectation count is snapshotted at the event so
    // expectations queued for the next edge are not consumed early.
    initial begin
        int            n;
        logic [DW-1:0] e;
        logic [DW-1:0] a;
        int            s;
        string         nm;
        forever begin
            @(posedge clk or negedge reset_n);
            n = chk_req;
            chk_req = 0;
            #1;
            for (int k = 0; k < n; k++) begin
                e  = exp_q.pop_front();
                s  = sel_q.pop_front();
                nm = name_q.pop_front();
                a  = actual(s);
                chk_cnt = chk_cnt + 1;
                if (a !== e) begin
                    $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, a, e, $time);
                end else begin
                    pass_cnt = pass_cnt + 1;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic we, input int a, input logic [DW-1:0] d,
                         input logic [NCH-1:0] rdy);
        @(negedge clk);
        wEn      = we;
        addr     = AW'(a);
        dataIn   = d;
        ch_ready = rdy;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        drive(0, 100, 0, '0);
        expect_val(SEL_DOUT,  0, "reset_dout");
        expect_val(SEL_VALID, 0, "reset_valid");
        expect_val(SEL_OVR,   0, "reset_ovr");
        expect_val(SEL_VAL0,  0, "reset_val0");

        // 1: RAM write/read, including first and last RAM words
        drive(1, 3, 32'h5, '0);
        expect_val(SEL_DOUT,  0, "ram_wr_dout_hold");
        expect_val(SEL_VALID, 0, "ram_wr_no_valid");
        drive(0, 3, 0, '0);
        expect_val(SEL_DOUT, 32'h5, "ram_rd3");
        drive(1, 0, 32'hAAAA, '0);
        drive(1, 19, 32'h1919, '0);
        drive(1, 4, 32'h44, '0);
        drive(0, 0, 0, '0);
        expect_val(SEL_DOUT, 32'hAAAA, "ram_rd0");
        drive(0, 19, 0, '0);
        expect_val(SEL_DOUT, 32'h1919, "ram_rd19");

        // 2: channel 1 write then handshake
        drive(1, 10, 32'h1234, '0);
        expect_val(SEL_VALID, 32'h02, "ch1_valid_set");
        expect_val(SEL_VAL0+1, 32'h1234, "ch1_value");
        drive(0, 100, 0, 5'b00010);
        expect_val(SEL_VALID, 0, "ch1_valid_clr");
        expect_val(SEL_VAL0+1, 32'h1234, "ch1_value_hold");
        expect_val(SEL_OVR, 0, "ch1_no_ovr");
        drive(0, 10, 0, '0);
        expect_val(SEL_DOUT, 32'h1234, "ch1_readback");

        // 3: overrun on channel 0, status read, W1C
        drive(1, 9, 32'hA, '0);
        expect_val(SEL_VALID, 32'h01, "ch0_valid");
        drive(1, 9, 32'hB, '0);
        expect_val(SEL_VAL0, 32'hB, "ch0_new_wins");
        expect_val(SEL_OVR, 32'h01, "ch0_ovr_set");
        drive(0, 14, 0, '0);
        expect_val(SEL_DOUT, 32'h21, "status_21");
        drive(1, 14, 32'h20, '0);
        expect_val(SEL_OVR, 0, "ch0_ovr_w1c");
        drive(0, 14, 0, '0);
        expect_val(SEL_DOUT, 32'h01, "status_01");
        drive(1, 14, 32'hFFFF_FC1F, '0);
        expect_val(SEL_VALID, 32'h01, "status_wr_pending_ignored");
        drive(0, 100, 0, 5'b00001);
        expect_val(SEL_VALID, 0, "ch0_consumed");

        // 4: transfer and write on the same edge
        drive(1, 11, 32'h3, '0);
        expect_val(SEL_VALID, 32'h04, "ch2_valid");
        drive(1, 11, 32'h7, 5'b00100);
        expect_val(SEL_VALID, 32'h04, "ch2_valid_stays");
        expect_val(SEL_VAL0+2, 32'h7, "ch2_value_new");
        expect_val(SEL_OVR, 0, "ch2_no_ovr");
        drive(0, 100, 0, 5'b00100);
        expect_val(SEL_VALID, 0, "ch2_consumed");
        drive(0, 100, 0, 5'b11111);
        expect_val(SEL_VALID, 0, "ready_no_valid");
        expect_val(SEL_OVR, 0, "ready_no_valid_ovr");

        // 5: unmapped accesses, dataOut hold on writes
        drive(0, 3, 0, '0);
        expect_val(SEL_DOUT, 32'h5, "ram_rd3_again");
        drive(1, 100, 32'hDEAD, '0);
        expect_val(SEL_DOUT, 32'h5, "dout_hold_unmapped_wr");
        expect_val(SEL_VALID, 0, "unmapped_no_valid");
        drive(1, 20, 32'h2020, '0);
        drive(0, 100, 0, '0);
        expect_val(SEL_DOUT, 0, "unmapped_rd100");
        drive(0, 20, 0, '0);
        expect_val(SEL_DOUT, 0, "unmapped_rd20");
        drive(0, 4, 0, '0);
        expect_val(SEL_DOUT, 32'h44, "ram4_untouched");
        drive(0, 3, 0, '0);
        expect_val(SEL_DOUT, 32'h5, "ram3_untouched");

        // 6: asynchronous reset while channels are pending
        drive(1, 12, 32'h99, '0);
        drive(1, 12, 32'h98, '0);
        expect_val(SEL_VALID, 32'h08, "ch3_valid");
        expect_val(SEL_OVR, 32'h08, "ch3_ovr");
        drive(0, 3, 0, '0);
        expect_val(SEL_DOUT, 32'h5, "pre_reset_dout");
        @(negedge clk);
        #2;
        expect_val(SEL_DOUT, 0, "async_rst_dout");
        expect_val(SEL_VALID, 0, "async_rst_valid");
        expect_val(SEL_OVR, 0, "async_rst_ovr");
        expect_val(SEL_VAL0+3, 0, "async_rst_val3");
        expect_val(SEL_VAL0+2, 0, "async_rst_val2");
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Every queued expectation must have been consumed.
        chk_cnt = chk_cnt + 1;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end else begin
            pass_cnt = pass_cnt + 1;
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
